// File: rtl/multi_cycle_ctrl_if.sv
// Control/status bundle between the multi-cycle MIPS controller and its datapath.
interface multi_cycle_ctrl_if;
  logic [5:0] OPcode;
  logic [5:0] Fun;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrc_B;
  logic [1:0] PCSource;
  logic [2:0] ALU_Control;
  logic [3:0] state_out;
  logic       inst_done;
  logic       err;

  // Controller side: decodes instruction fields, drives the datapath controls.
  modport master (
    input  OPcode, Fun, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrc_B, PCSource, ALU_Control,
           state_out, inst_done, err
  );

  // Datapath side: supplies instruction fields and status, consumes controls.
  modport slave (
    output OPcode, Fun, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrc_B, PCSource, ALU_Control,
           state_out, inst_done, err
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB over a shared datapath,
// stalls on mem_ready and parks in a sticky ERR state on illegal opcodes or memory timeouts.
module multi_cycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  multi_cycle_ctrl_if.master bus
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_LWWB = 4'd4,
    S_MWR  = 4'd5,
    S_REX  = 4'd6,
    S_RWB  = 4'd7,
    S_BEQ  = 4'd8,
    S_J    = 4'd9,
    S_IEX  = 4'd10,
    S_IWB  = 4'd11,
    S_ERR  = 4'd15
  } state_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_sw_q, is_sw_d;      // memory op chosen in ID: 1 = sw, 0 = lw
  logic [2:0]       imm_alu_q, imm_alu_d;  // I-type ALU op chosen in ID

  logic       pc_write_c, pc_write_cond_c, iord_c, mem_read_c, mem_write_c;
  logic       ir_write_c, mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, pc_source_c;
  logic [2:0] alu_control_c;
  logic [3:0] state_out_c;
  logic       inst_done_c, err_c;

  // The zero flag is consumed by the datapath's PC-write gating, not by the FSM.
  logic unused_zero;
  assign unused_zero = bus.zero;

  // State, wait counter and decode latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      cnt_q     <= '0;
      is_sw_q   <= 1'b0;
      imm_alu_q <= ALU_ADD;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_sw_q   <= is_sw_d;
      imm_alu_q <= imm_alu_d;
    end
  end

  // Next state, wait counter and per-state control decode.
  always_comb begin
    state_d         = state_q;
    cnt_d           = '0;
    is_sw_d         = is_sw_q;
    imm_alu_d       = imm_alu_q;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    iord_c          = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_dst_c       = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'b00;
    pc_source_c     = 2'b00;
    alu_control_c   = ALU_ADD;
    state_out_c     = 4'(state_q);
    inst_done_c     = 1'b0;
    err_c           = 1'b0;

    unique case (state_q)
      S_IF: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = bus.mem_ready;
        pc_write_c  = bus.mem_ready;
        if (bus.mem_ready)        state_d = S_ID;
        else if (cnt_q == TIMEOUT) state_d = S_ERR;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      S_ID: begin
        alu_src_b_c = 2'b11;
        unique case (bus.OPcode)
          6'b000000: state_d = S_REX;
          6'b100011: begin state_d = S_MADR; is_sw_d = 1'b0; end
          6'b101011: begin state_d = S_MADR; is_sw_d = 1'b1; end
          6'b000100: state_d = S_BEQ;
          6'b000010: state_d = S_J;
          6'b001000: begin state_d = S_IEX; imm_alu_d = ALU_ADD; end
          6'b001010: begin state_d = S_IEX; imm_alu_d = ALU_SLT; end
          6'b001100: begin state_d = S_IEX; imm_alu_d = ALU_AND; end
          6'b001101: begin state_d = S_IEX; imm_alu_d = ALU_OR;  end
          default:   state_d = S_ERR;
        endcase
      end
      S_MADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = is_sw_q ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_read_c = 1'b1;
        iord_c     = 1'b1;
        if (bus.mem_ready)        state_d = S_LWWB;
        else if (cnt_q == TIMEOUT) state_d = S_ERR;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      S_LWWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        inst_done_c  = 1'b1;
        state_d      = S_IF;
      end
      S_MWR: begin
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
        inst_done_c = bus.mem_ready;
        if (bus.mem_ready)        state_d = S_IF;
        else if (cnt_q == TIMEOUT) state_d = S_ERR;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      S_REX: begin
        alu_src_a_c = 1'b1;
        state_d     = S_RWB;
        unique case (bus.Fun)
          6'b100000: alu_control_c = ALU_ADD;
          6'b100010: alu_control_c = ALU_SUB;
          6'b100100: alu_control_c = ALU_AND;
          6'b100101: alu_control_c = ALU_OR;
          6'b101010: alu_control_c = ALU_SLT;
          6'b100111: alu_control_c = ALU_NOR;
          default:   state_d       = S_ERR;
        endcase
      end
      S_RWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        inst_done_c = 1'b1;
        state_d     = S_IF;
      end
      S_BEQ: begin
        alu_src_a_c     = 1'b1;
        alu_control_c   = ALU_SUB;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 2'b01;
        inst_done_c     = 1'b1;
        state_d         = S_IF;
      end
      S_J: begin
        pc_write_c  = 1'b1;
        pc_source_c = 2'b10;
        inst_done_c = 1'b1;
        state_d     = S_IF;
      end
      S_IEX: begin
        alu_src_a_c   = 1'b1;
        alu_src_b_c   = 2'b10;
        alu_control_c = imm_alu_q;
        state_d       = S_IWB;
      end
      S_IWB: begin
        reg_write_c = 1'b1;
        inst_done_c = 1'b1;
        state_d     = S_IF;
      end
      S_ERR: begin
        alu_control_c = 3'b000;
        err_c         = 1'b1;
      end
      default: begin
        alu_control_c = 3'b000;
        state_d       = S_ERR;
      end
    endcase

    // Reset silences every control so an aborted instruction issues no write.
    if (rst) begin
      pc_write_c      = 1'b0;
      pc_write_cond_c = 1'b0;
      iord_c          = 1'b0;
      mem_read_c      = 1'b0;
      mem_write_c     = 1'b0;
      ir_write_c      = 1'b0;
      mem_to_reg_c    = 1'b0;
      reg_dst_c       = 1'b0;
      reg_write_c     = 1'b0;
      alu_src_a_c     = 1'b0;
      alu_src_b_c     = 2'b00;
      pc_source_c     = 2'b00;
      alu_control_c   = 3'b000;
      state_out_c     = 4'd0;
      inst_done_c     = 1'b0;
      err_c           = 1'b0;
    end
  end

  assign bus.PCWrite     = pc_write_c;
  assign bus.PCWriteCond = pc_write_cond_c;
  assign bus.IorD        = iord_c;
  assign bus.MemRead     = mem_read_c;
  assign bus.MemWrite    = mem_write_c;
  assign bus.IRWrite     = ir_write_c;
  assign bus.MemtoReg    = mem_to_reg_c;
  assign bus.RegDst      = reg_dst_c;
  assign bus.RegWrite    = reg_write_c;
  assign bus.ALUSrcA     = alu_src_a_c;
  assign bus.ALUSrc_B    = alu_src_b_c;
  assign bus.PCSource    = pc_source_c;
  assign bus.ALU_Control = alu_control_c;
  assign bus.state_out   = state_out_c;
  assign bus.inst_done   = inst_done_c;
  assign bus.err         = err_c;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl (MEM_TIMEOUT=3): every control output is compared
// each checked cycle against a hand-built expected vector.
module tb_multi_cycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl #(.MEM_TIMEOUT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,
  //  ALUSrc_B,PCSource,ALU_Control,state_out,inst_done,err}
  logic [22:0] obs;
  assign obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrc_B, bus.PCSource, bus.ALU_Control, bus.state_out,
                bus.inst_done, bus.err};

  function automatic logic [22:0] cv(input logic [9:0] flags, input logic [1:0] srcb,
                                     input logic [1:0] pcsrc, input logic [2:0] alu,
                                     input logic [3:0] st, input logic done, input logic er);
    return {flags, srcb, pcsrc, alu, st, done, er};
  endfunction

  logic [22:0] E_ZERO, E_IF_WAIT, E_IF_RDY, E_ID, E_MADR, E_MRD, E_LWWB, E_MWR, E_MWR_DONE;
  logic [22:0] E_RWB, E_BEQ, E_J, E_IWB, E_ERR;

  function automatic logic [22:0] e_rex(input logic [2:0] alu);
    return cv(10'b0000000001, 2'b00, 2'b00, alu, 4'd6, 1'b0, 1'b0);
  endfunction

  function automatic logic [22:0] e_iex(input logic [2:0] alu);
    return cv(10'b0000000001, 2'b10, 2'b00, alu, 4'd10, 1'b0, 1'b0);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [22:0] exp);
    #1;
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Fetch (mem_ready=1) and decode; returns one cycle after ID.
  task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fun);
    bus.mem_ready = 1'b1;
    bus.OPcode    = op;
    bus.Fun       = fun;
    chk({tag, "_if"}, E_IF_RDY);
    tick;
    chk({tag, "_id"}, E_ID);
    tick;
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    chk({tag, "_rst"}, E_ZERO);
    tick;
    rst = 1'b0;
  endtask

  logic [5:0] imm_ops [4];
  logic [2:0] imm_alu [4];

  initial begin
    E_ZERO     = '0;
    E_IF_WAIT  = cv(10'b0001000000, 2'b01, 2'b00, 3'b010, 4'd0,  1'b0, 1'b0);
    E_IF_RDY   = cv(10'b1001010000, 2'b01, 2'b00, 3'b010, 4'd0,  1'b0, 1'b0);
    E_ID       = cv(10'b0000000000, 2'b11, 2'b00, 3'b010, 4'd1,  1'b0, 1'b0);
    E_MADR     = cv(10'b0000000001, 2'b10, 2'b00, 3'b010, 4'd2,  1'b0, 1'b0);
    E_MRD      = cv(10'b0011000000, 2'b00, 2'b00, 3'b010, 4'd3,  1'b0, 1'b0);
    E_LWWB     = cv(10'b0000001010, 2'b00, 2'b00, 3'b010, 4'd4,  1'b1, 1'b0);
    E_MWR      = cv(10'b0010100000, 2'b00, 2'b00, 3'b010, 4'd5,  1'b0, 1'b0);
    E_MWR_DONE = cv(10'b0010100000, 2'b00, 2'b00, 3'b010, 4'd5,  1'b1, 1'b0);
    E_RWB      = cv(10'b0000000110, 2'b00, 2'b00, 3'b010, 4'd7,  1'b1, 1'b0);
    E_BEQ      = cv(10'b0100000001, 2'b00, 2'b01, 3'b110, 4'd8,  1'b1, 1'b0);
    E_J        = cv(10'b1000000000, 2'b00, 2'b10, 3'b010, 4'd9,  1'b1, 1'b0);
    E_IWB      = cv(10'b0000000010, 2'b00, 2'b00, 3'b010, 4'd11, 1'b1, 1'b0);
    E_ERR      = cv(10'b0000000000, 2'b00, 2'b00, 3'b000, 4'd15, 1'b0, 1'b1);
    imm_ops = '{6'b001000, 6'b001010, 6'b001100, 6'b001101};
    imm_alu = '{3'b010,    3'b111,    3'b000,    3'b001};

    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.OPcode = '0;
    bus.Fun = '0;
    bus.zero = 1'b0;

    // Reset held two clocks: everything silent.
    tick; chk("rst_c1", E_ZERO);
    tick; chk("rst_c2", E_ZERO);
    rst = 1'b0;
    chk("if_after_rst", E_IF_WAIT);

    // add: IF, ID, REX(ADD), RWB.
    fetch_decode("add", 6'b000000, 6'b100000);
    chk("add_rex", e_rex(3'b010)); tick;
    chk("add_rwb", E_RWB); tick;

    // sub and nor decode in REX.
    fetch_decode("sub", 6'b000000, 6'b100010);
    chk("sub_rex", e_rex(3'b110)); tick;
    chk("sub_rwb", E_RWB); tick;
    fetch_decode("nor", 6'b000000, 6'b100111);
    chk("nor_rex", e_rex(3'b100)); tick;
    chk("nor_rwb", E_RWB); tick;

    // lw with three not-ready cycles; ready arrives with count == MEM_TIMEOUT.
    fetch_decode("lw", 6'b100011, 6'b000000);
    chk("lw_madr", E_MADR); tick;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin chk("lw_mrd_wait", E_MRD); tick; end
    bus.mem_ready = 1'b1;
    chk("lw_mrd_rdy", E_MRD); tick;
    chk("lw_wb", E_LWWB); tick;

    // sw; OPcode flips to lw in MADR and must be ignored.
    fetch_decode("sw", 6'b101011, 6'b000000);
    bus.OPcode = 6'b100011;
    chk("sw_madr", E_MADR); tick;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin chk("sw_mwr_wait", E_MWR); tick; end
    bus.mem_ready = 1'b1;
    chk("sw_mwr_rdy", E_MWR_DONE); tick;

    // beq with zero=1 then zero=0, then j.
    bus.zero = 1'b1;
    fetch_decode("beq1", 6'b000100, 6'b000000);
    chk("beq1_ex", E_BEQ); tick;
    bus.zero = 1'b0;
    fetch_decode("beq0", 6'b000100, 6'b000000);
    chk("beq0_ex", E_BEQ); tick;
    fetch_decode("j", 6'b000010, 6'b000000);
    chk("j_ex", E_J); tick;

    // I-type ops; OPcode scrambled during IEX to confirm the ID-time latch.
    for (int i = 0; i < 4; i++) begin
      fetch_decode("imm", imm_ops[i], 6'b000000);
      bus.OPcode = 6'b111111;
      chk("imm_iex", e_iex(imm_alu[i])); tick;
      chk("imm_iwb", E_IWB); tick;
    end

    // Illegal opcode -> sticky ERR; reset clears it.
    fetch_decode("badop", 6'b111111, 6'b000000);
    chk("badop_err", E_ERR); tick;
    bus.OPcode = 6'b000000;
    chk("badop_held", E_ERR); tick;
    chk("badop_held2", E_ERR);
    reset_pulse("badop");
    chk("badop_if", E_IF_RDY);

    // R-type with unknown Fun -> ERR without register write.
    fetch_decode("badfun", 6'b000000, 6'b000000);
    chk("badfun_rex", e_rex(3'b010)); tick;
    chk("badfun_err", E_ERR); tick;
    chk("badfun_held", E_ERR);
    reset_pulse("badfun");

    // Fetch timeout: four not-ready cycles in IF, then ERR.
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin chk("if_timeout_wait", E_IF_WAIT); tick; end
    chk("if_timeout_err", E_ERR);
    reset_pulse("iftmo");

    // Reset during MRD aborts the load.
    fetch_decode("lwrst", 6'b100011, 6'b000000);
    chk("lwrst_madr", E_MADR); tick;
    chk("lwrst_mrd", E_MRD);
    reset_pulse("lwrst");
    chk("lwrst_if", E_IF_RDY);

    // Store timeout in MWR.
    fetch_decode("swtmo", 6'b101011, 6'b000000);
    chk("swtmo_madr", E_MADR); tick;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin chk("swtmo_wait", E_MWR); tick; end
    chk("swtmo_err", E_ERR);
    reset_pulse("swtmo");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
